// File: rtl/expr_vector_sequencer.sv
// expr_vector_sequencer: drives LFSR operand vectors into an expression datapath and
// compacts its results into a 32-bit MISR signature checked against exp_sig.
module expr_vector_sequencer #(
    parameter int          NVEC = 256,
    parameter int          LAT  = 0,
    parameter logic [63:0] SEED = 64'h1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] exp_sig,
    output logic [29:0] op_a,
    output logic [29:0] op_b,
    input  logic [89:0] y_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] sig,
    output logic        pass,
    output logic        aborted
);
    localparam logic [63:0] SEED_E = (SEED == 64'd0) ? 64'd1 : SEED;
    localparam logic [15:0] VLAST  = 16'(NVEC - 1);
    localparam logic [2:0]  WLAST  = (LAT > 0) ? 3'(LAT - 1) : 3'd0;

    typedef enum logic [2:0] {IDLE, LOAD, WAIT, SAMPLE, DONE} state_t;

    state_t      state_q;
    logic [63:0] lfsr_q, lfsr_d;
    logic [29:0] op_a_q, op_b_q;
    logic [31:0] sig_q, sig_d, fold;
    logic [15:0] vcnt_q;
    logic [2:0]  wcnt_q;
    logic        done_q, pass_q, aborted_q;

    assign lfsr_d  = {lfsr_q[62:0], lfsr_q[63] ^ lfsr_q[62] ^ lfsr_q[60] ^ lfsr_q[59]};
    assign fold    = y_in[31:0] ^ y_in[63:32] ^ {6'b0, y_in[89:64]};
    assign sig_d   = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? 32'h04C11DB7 : 32'h0) ^ fold;
    assign busy    = (state_q == LOAD) || (state_q == WAIT) || (state_q == SAMPLE);
    assign op_a    = op_a_q;
    assign op_b    = op_b_q;
    assign done    = done_q;
    assign sig     = sig_q;
    assign pass    = pass_q;
    assign aborted = aborted_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            lfsr_q    <= SEED_E;
            op_a_q    <= '0;
            op_b_q    <= '0;
            sig_q     <= '0;
            vcnt_q    <= '0;
            wcnt_q    <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // abort freezes all run state except the flag; DONE is not busy, so it completes
            if (abort && busy) begin
                state_q   <= IDLE;
                aborted_q <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: if (start && !abort) begin
                        state_q   <= LOAD;
                        lfsr_q    <= SEED_E;
                        sig_q     <= 32'hFFFFFFFF;
                        vcnt_q    <= '0;
                        aborted_q <= 1'b0;
                    end
                    LOAD: begin
                        op_a_q  <= lfsr_q[59:30];
                        op_b_q  <= lfsr_q[29:0];
                        lfsr_q  <= lfsr_d;
                        wcnt_q  <= '0;
                        state_q <= (LAT > 0) ? WAIT : SAMPLE;
                    end
                    WAIT: begin
                        wcnt_q  <= wcnt_q + 3'd1;
                        state_q <= (wcnt_q == WLAST) ? SAMPLE : WAIT;
                    end
                    SAMPLE: begin
                        sig_q   <= sig_d;
                        vcnt_q  <= vcnt_q + 16'd1;
                        state_q <= (vcnt_q == VLAST) ? DONE : LOAD;
                    end
                    DONE: begin
                        done_q  <= 1'b1;
                        pass_q  <= (sig_q == exp_sig);
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_expr_vector_sequencer.sv
// tb_expr_vector_sequencer: directed runs on two instances (NVEC=1/LAT=0 with y_in=0, and
// NVEC=4/LAT=3 with a stand-in datapath); done events are checked against a scoreboard.
module tb_expr_vector_sequencer;
    localparam logic [63:0] SEED2 = 64'h0123_4567_89AB_CDEF;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int ncmp = 0;
    int nfail = 0;

    typedef struct {
        logic [31:0] s;
        logic        p;
        int          c;
    } exp_t;
    exp_t q1[$];
    exp_t q2[$];

    function automatic exp_t mk(logic [31:0] s, logic p, int c);
        exp_t e;
        e.s = s;
        e.p = p;
        e.c = c;
        return e;
    endfunction

    function automatic logic [63:0] step(logic [63:0] s);
        return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
    endfunction

    function automatic logic [31:0] misr(logic [31:0] s, logic [89:0] y);
        logic [31:0] f;
        f = y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]};
        return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ f;
    endfunction

    function automatic logic [89:0] dp(logic [29:0] a, logic [29:0] b);
        return {60'(a) * 60'(b), a ^ b};
    endfunction

    function automatic logic [31:0] run_sig(logic [63:0] seed, int n);
        logic [63:0] l;
        logic [31:0] s;
        l = seed;
        s = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            s = misr(s, dp(l[59:30], l[29:0]));
            l = step(l);
        end
        return s;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    logic        start1 = 1'b0, abort1 = 1'b0;
    logic [31:0] exp1 = '0;
    logic [29:0] opa1, opb1;
    logic [89:0] y1 = '0;
    logic        busy1, done1, pass1, ab1;
    logic [31:0] sig1;

    logic        start2 = 1'b0, abort2 = 1'b0;
    logic [31:0] exp2 = '0;
    logic [29:0] opa2, opb2;
    logic [89:0] y2;
    logic        busy2, done2, pass2, ab2;
    logic [31:0] sig2;

    assign y2 = dp(opa2, opb2);

    expr_vector_sequencer #(.NVEC(1), .LAT(0), .SEED(64'h1)) d1 (
        .clk(clk), .reset(reset), .start(start1), .abort(abort1), .exp_sig(exp1),
        .op_a(opa1), .op_b(opb1), .y_in(y1), .busy(busy1), .done(done1),
        .sig(sig1), .pass(pass1), .aborted(ab1)
    );

    expr_vector_sequencer #(.NVEC(4), .LAT(3), .SEED(SEED2)) d2 (
        .clk(clk), .reset(reset), .start(start2), .abort(abort2), .exp_sig(exp2),
        .op_a(opa2), .op_b(opb2), .y_in(y2), .busy(busy2), .done(done2),
        .sig(sig2), .pass(pass2), .aborted(ab2)
    );

    always @(negedge clk) begin
        if (done1) begin
            if (q1.size() == 0) chk("d1_unexpected_done", 1, 0);
            else begin
                exp_t e;
                e = q1.pop_front();
                chk("d1_sig", sig1, e.s);
                chk("d1_pass", pass1, e.p);
                chk("d1_done_cycle", cyc, e.c);
            end
        end
    end

    always @(negedge clk) begin
        if (done2) begin
            if (q2.size() == 0) chk("d2_unexpected_done", 1, 0);
            else begin
                exp_t e;
                e = q2.pop_front();
                chk("d2_sig", sig2, e.s);
                chk("d2_pass", pass2, e.p);
                chk("d2_done_cycle", cyc, e.c);
            end
        end
    end

    initial begin
        logic [31:0] esig, sv1;
        logic [29:0] oa, ob;
        int c;
        esig = run_sig(SEED2, 4);
        sv1  = run_sig(SEED2, 1);
        tick(3);
        chk("rst_op_a", opa2, 0);
        chk("rst_op_b", opb2, 0);
        chk("rst_sig", sig2, 0);
        chk("rst_busy", busy2, 0);
        chk("rst_done", done2, 0);
        chk("rst_pass", pass2, 0);
        chk("rst_aborted", ab2, 0);
        chk("rst_d1_sig", sig1, 0);
        reset = 1'b0;

        exp1 = 32'hFB3EE249;
        start1 = 1'b1;
        q1.push_back(mk(32'hFB3EE249, 1'b1, cyc + 4));
        tick(1);
        start1 = 1'b0;
        tick(1);
        chk("d1_op_a", opa1, 0);
        chk("d1_op_b", opb1, 1);
        tick(4);

        exp2 = esig;
        start2 = 1'b1;
        q2.push_back(mk(esig, 1'b1, cyc + 22));
        tick(1);
        start2 = 1'b0;
        tick(24);

        exp2 = esig ^ 32'h1;
        start2 = 1'b1;
        q2.push_back(mk(esig, 1'b0, cyc + 22));
        tick(1);
        start2 = 1'b0;
        tick(22);
        chk("bad_pass_after", pass2, 0);
        chk("bad_sig_after", sig2, esig);
        tick(3);
        chk("sig_hold", sig2, esig);

        start2 = 1'b1;
        tick(1);
        start2 = 1'b0;
        tick(1);
        oa = opa2;
        ob = opb2;
        tick(3);
        chk("op_a_stable", opa2, oa);
        chk("op_b_stable", opb2, ob);
        tick(2);
        chk("busy_in_wait", busy2, 1);
        abort2 = 1'b1;
        tick(1);
        abort2 = 1'b0;
        chk("abort_busy", busy2, 0);
        chk("abort_flag", ab2, 1);
        chk("abort_sig", sig2, sv1);
        tick(25);
        chk("abort_sig_hold", sig2, sv1);

        exp2 = esig;
        start2 = 1'b1;
        c = cyc;
        q2.push_back(mk(esig, 1'b1, c + 22));
        q2.push_back(mk(esig, 1'b1, c + 44));
        tick(1);
        chk("aborted_cleared", ab2, 0);
        tick(22);
        start2 = 1'b0;
        tick(22);

        start2 = 1'b1;
        q2.push_back(mk(esig, 1'b1, cyc + 22));
        tick(1);
        start2 = 1'b0;
        tick(20);
        abort2 = 1'b1;
        tick(1);
        abort2 = 1'b0;
        chk("done_abort_flag", ab2, 0);
        tick(2);

        start2 = 1'b1;
        abort2 = 1'b1;
        tick(2);
        start2 = 1'b0;
        abort2 = 1'b0;
        chk("sa_idle_busy", busy2, 0);
        chk("sa_idle_sig", sig2, esig);
        tick(3);

        start2 = 1'b1;
        tick(1);
        start2 = 1'b0;
        tick(4);
        chk("busy_in_sample", busy2, 1);
        reset = 1'b1;
        tick(1);
        chk("mid_rst_op_a", opa2, 0);
        chk("mid_rst_op_b", opb2, 0);
        chk("mid_rst_sig", sig2, 0);
        chk("mid_rst_done", done2, 0);
        chk("mid_rst_pass", pass2, 0);
        chk("mid_rst_aborted", ab2, 0);
        chk("mid_rst_busy", busy2, 0);
        reset = 1'b0;
        start2 = 1'b1;
        abort2 = 1'b1;
        tick(4);
        start2 = 1'b0;
        abort2 = 1'b0;
        chk("post_rst_busy", busy2, 0);
        chk("post_rst_sig", sig2, 0);
        chk("post_rst_op_b", opb2, 0);
        tick(2);
        chk("d1_queue_empty", q1.size(), 0);
        chk("d2_queue_empty", q2.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
